tea_cbc_ctrl: RTL and testbench

//  Initiator/driver for the tea_top core's start/done interface: owns the core's handshake, so no bench or CPU sequences it by hand.

---
 rtl/tea_pkg.sv | 46 ++++
 rtl/tea_cbc_ctrl.sv | 161 ++++++++++++++++
 tb/tb_tea_cbc_ctrl.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tea_pkg.sv
// Shared types and constants for the TEA CBC controller.
//  MODE_ENC/MODE_DEC : cfg_mode / core_mode encoding
//  BLK_W, KEY_W      : block and key widths
//  ST_*              : state encoding of the controller FSM
//  blk_t, key_t      : packed payloads for a 64-bit block and a 128-bit key
package tea_pkg;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BLK_W  = 64;
    localparam int unsigned KEY_W  = 128;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_ISSUE = ST_ISSUE,
        S_WAIT  = ST_WAIT,
        S_OUT   = ST_OUT
    } state_t;

    // {v0,v1}, v0 in the upper word
    typedef struct packed {
        logic [WORD_W-1:0] v0;
        logic [WORD_W-1:0] v1;
    } blk_t;

    // {k0,k1,k2,k3}, k0 in the upper word
    typedef struct packed {
        logic [WORD_W-1:0] k0;
        logic [WORD_W-1:0] k1;
        logic [WORD_W-1:0] k2;
        logic [WORD_W-1:0] k3;
    } key_t;

    // Bitwise 64-bit XOR of two blocks (no carries between words)
    function automatic blk_t blk_xor(input blk_t a, input blk_t b);
        return blk_t'(BLK_W'(a) ^ BLK_W'(b));
    endfunction

endpackage

// File: rtl/tea_cbc_ctrl.sv
// Drives a tea_top core through its start/done handshake, one block at a
// time, with optional CBC chaining around the core and a completion watchdog.
//  clk, rst            : clock, asynchronous active-high reset
//  cfg_mode/cfg_key    : direction and key, sampled when a block is accepted
//  cfg_iv/cfg_load     : IV load pulse (IDLE only), also clears err_timeout
//  s_valid/s_ready/s_data : input block stream
//  m_valid/m_ready/m_data : result block stream
//  busy, err_timeout   : status (err_timeout is sticky)
//  core_*              : start/mode/block/key to tea_top, result/done back
module tea_cbc_ctrl
    import tea_pkg::*;
#(
    parameter bit          CBC_EN    = 1'b1,
    parameter int unsigned TO_CYCLES = 255,
    parameter int unsigned TO_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_mode,
    input  logic [KEY_W-1:0]    cfg_key,
    input  logic [BLK_W-1:0]    cfg_iv,
    input  logic                cfg_load,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [BLK_W-1:0]    s_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [BLK_W-1:0]    m_data,
    output logic                busy,
    output logic                err_timeout,
    output logic                core_start,
    output logic                core_mode,
    output logic [WORD_W-1:0]   core_v0,
    output logic [WORD_W-1:0]   core_v1,
    output logic [WORD_W-1:0]   core_k0,
    output logic [WORD_W-1:0]   core_k1,
    output logic [WORD_W-1:0]   core_k2,
    output logic [WORD_W-1:0]   core_k3,
    input  logic [WORD_W-1:0]   core_v0_out,
    input  logic [WORD_W-1:0]   core_v1_out,
    input  logic                core_done
);

    state_t          state;
    logic            rdy_q;
    logic            mode_q;
    key_t            key_q;
    blk_t            core_blk_q;
    blk_t            chain_q;
    blk_t            ct_q;
    blk_t            m_blk_q;
    logic            done_q;
    logic [TO_W-1:0] wd_q;

    blk_t s_blk_c;
    blk_t core_out_c;
    blk_t x_c;
    logic done_rise_c;
    logic wd_exp_c;

    // Chaining term: previous ciphertext / IV in CBC, zero in ECB
    assign x_c         = CBC_EN ? chain_q : blk_t'(BLK_W'(0));
    assign s_blk_c     = blk_t'(s_data);
    assign core_out_c  = blk_t'({core_v0_out, core_v1_out});
    // Only a fresh edge counts, so a done level left over from the last op is ignored
    assign done_rise_c = core_done & ~done_q;
    assign wd_exp_c    = (wd_q == TO_W'(TO_CYCLES - 1));

    // cfg_load must block acceptance in the same cycle, hence not registered
    assign s_ready = rdy_q & ~cfg_load;

    assign m_data    = BLK_W'(m_blk_q);
    assign core_mode = mode_q;
    assign core_v0   = core_blk_q.v0;
    assign core_v1   = core_blk_q.v1;
    assign core_k0   = key_q.k0;
    assign core_k1   = key_q.k1;
    assign core_k2   = key_q.k2;
    assign core_k3   = key_q.k3;

    // Controller FSM with registered handshake/status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            rdy_q       <= 1'b0;
            busy        <= 1'b0;
            m_valid     <= 1'b0;
            core_start  <= 1'b0;
            err_timeout <= 1'b0;
            mode_q      <= MODE_ENC;
            key_q       <= key_t'(KEY_W'(0));
            core_blk_q  <= blk_t'(BLK_W'(0));
            chain_q     <= blk_t'(BLK_W'(0));
            ct_q        <= blk_t'(BLK_W'(0));
            m_blk_q     <= blk_t'(BLK_W'(0));
            done_q      <= 1'b0;
            wd_q        <= TO_W'(0);
        end else begin
            done_q     <= core_done;
            core_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    rdy_q <= 1'b1;
                    busy  <= 1'b0;
                    if (cfg_load) begin
                        chain_q     <= blk_t'(cfg_iv);
                        err_timeout <= 1'b0;
                    end else if (s_valid && rdy_q) begin
                        mode_q <= cfg_mode;
                        key_q  <= key_t'(cfg_key);
                        if (cfg_mode == MODE_DEC) begin
                            core_blk_q <= s_blk_c;
                            ct_q       <= s_blk_c;
                        end else begin
                            core_blk_q <= blk_xor(s_blk_c, x_c);
                        end
                        core_start <= 1'b1;
                        rdy_q      <= 1'b0;
                        busy       <= 1'b1;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wd_q  <= TO_W'(0);
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (done_rise_c) begin
                        if (mode_q == MODE_DEC) begin
                            m_blk_q <= blk_xor(core_out_c, x_c);
                            chain_q <= ct_q;
                        end else begin
                            m_blk_q <= core_out_c;
                            chain_q <= core_out_c;
                        end
                        m_valid <= 1'b1;
                        state   <= S_OUT;
                    end else if (wd_exp_c) begin
                        // Core never answered: drop the block, keep the chain
                        err_timeout <= 1'b1;
                        busy        <= 1'b0;
                        rdy_q       <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        wd_q <= wd_q + TO_W'(1);
                    end
                end
                S_OUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        busy    <= 1'b0;
                        rdy_q   <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tea_cbc_ctrl.sv
// Bench for tea_cbc_ctrl: a CBC instance (index 0) and an ECB instance
// (index 1), each attached to a behavioural TEA core with a fixed latency.
module tb_tea_cbc_ctrl;

    localparam logic ENC   = 1'b0;
    localparam logic DEC   = 1'b1;
    localparam int   LAT   = 6;
    localparam int   LIMIT = 100;

    localparam logic [63:0]  TEA0  = 64'h41EA3A0A_94BAA940;
    localparam logic [127:0] KEY3  = 128'h0A0B0C0D_0E0F1011_12131415_16171819;
    localparam logic [63:0]  IV3   = 64'h01234567_89ABCDEF;

    logic         clk = 1'b0;
    logic         rst;
    logic         cfg_mode;
    logic [127:0] cfg_key;
    logic [63:0]  cfg_iv;
    logic         cfg_load;
    logic [63:0]  s_data;
    logic         hang;

    logic        s_valid [2];
    logic        s_ready [2];
    logic        m_valid [2];
    logic        m_ready [2];
    logic [63:0] m_data  [2];
    logic        busy    [2];
    logic        err     [2];
    logic        cstart  [2];
    logic        cmode   [2];
    logic [31:0] cv0 [2], cv1 [2], ck0 [2], ck1 [2], ck2 [2], ck3 [2];
    logic [31:0] co0 [2], co1 [2];
    logic        cdone   [2];
    logic        mbusy   [2];
    int          mcnt    [2];

    int n_assert;
    int n_fail;

    always #5 clk = ~clk;

    tea_cbc_ctrl #(.CBC_EN(1'b1), .TO_CYCLES(16), .TO_W(5)) dut (
        .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_key(cfg_key),
        .cfg_iv(cfg_iv), .cfg_load(cfg_load),
        .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_data(s_data),
        .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_data(m_data[0]),
        .busy(busy[0]), .err_timeout(err[0]),
        .core_start(cstart[0]), .core_mode(cmode[0]),
        .core_v0(cv0[0]), .core_v1(cv1[0]),
        .core_k0(ck0[0]), .core_k1(ck1[0]), .core_k2(ck2[0]), .core_k3(ck3[0]),
        .core_v0_out(co0[0]), .core_v1_out(co1[0]), .core_done(cdone[0])
    );

    tea_cbc_ctrl #(.CBC_EN(1'b0), .TO_CYCLES(16), .TO_W(8)) dut_ecb (
        .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_key(cfg_key),
        .cfg_iv(cfg_iv), .cfg_load(cfg_load),
        .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_data(s_data),
        .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_data(m_data[1]),
        .busy(busy[1]), .err_timeout(err[1]),
        .core_start(cstart[1]), .core_mode(cmode[1]),
        .core_v0(cv0[1]), .core_v1(cv1[1]),
        .core_k0(ck0[1]), .core_k1(ck1[1]), .core_k2(ck2[1]), .core_k3(ck3[1]),
        .core_v0_out(co0[1]), .core_v1_out(co1[1]), .core_done(cdone[1])
    );

    function automatic logic [63:0] tea(input logic dec, input logic [63:0] v,
                                        input logic [127:0] k);
        logic [31:0] v0, v1, sum, k0, k1, k2, k3;
        v0 = v[63:32]; v1 = v[31:0];
        k0 = k[127:96]; k1 = k[95:64]; k2 = k[63:32]; k3 = k[31:0];
        if (!dec) begin
            sum = 32'h0;
            for (int r = 0; r < 32; r++) begin
                sum = sum + 32'h9E3779B9;
                v0 = v0 + ((((v1 << 4) + k0) ^ (v1 + sum)) ^ ((v1 >> 5) + k1));
                v1 = v1 + ((((v0 << 4) + k2) ^ (v0 + sum)) ^ ((v0 >> 5) + k3));
            end
        end else begin
            sum = 32'hC6EF3720;
            for (int r = 0; r < 32; r++) begin
                v1 = v1 - ((((v0 << 4) + k2) ^ (v0 + sum)) ^ ((v0 >> 5) + k3));
                v0 = v0 - ((((v1 << 4) + k0) ^ (v1 + sum)) ^ ((v1 >> 5) + k1));
                sum = sum - 32'h9E3779B9;
            end
        end
        return {v0, v1};
    endfunction

    // Behavioural core: done stays high until two cycles into the next op,
    // and the block/key are read only at completion.
    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                cdone[i] <= 1'b0; mbusy[i] <= 1'b0; mcnt[i] <= 0;
                co0[i] <= 32'h0; co1[i] <= 32'h0;
            end else if (cstart[i]) begin
                mbusy[i] <= 1'b1; mcnt[i] <= 0;
            end else if (mbusy[i]) begin
                mcnt[i] <= mcnt[i] + 1;
                if (mcnt[i] == 1) cdone[i] <= 1'b0;
                if (mcnt[i] == LAT) begin
                    mbusy[i] <= 1'b0;
                    if (!hang) begin
                        cdone[i] <= 1'b1;
                        {co0[i], co1[i]} <= tea(cmode[i], {cv0[i], cv1[i]},
                                                {ck0[i], ck1[i], ck2[i], ck3[i]});
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_iv(input logic [63:0] iv);
        @(negedge clk);
        cfg_iv = iv; cfg_load = 1'b1;
        @(posedge clk); #1 cfg_load = 1'b0;
    endtask

    // Checks on the cycle right after acceptance (ISSUE) and the one after
    task automatic issue_chk(input int sel);
        @(negedge clk);
        chk("start_pulse", {62'b0, cstart[sel], busy[sel]}, 64'd3);
        @(negedge clk);
        chk("start_single", {63'b0, cstart[sel]}, 64'd0);
    endtask

    task automatic send(input int sel, input logic [63:0] din, input logic mode);
        int n;
        @(negedge clk);
        cfg_mode = mode; s_data = din; s_valid[sel] = 1'b1;
        n = 0;
        while (!s_ready[sel] && n < LIMIT) begin @(negedge clk); n++; end
        chk("accept_wait", {63'b0, n < LIMIT}, 64'd1);
        @(posedge clk); #1 s_valid[sel] = 1'b0;
        issue_chk(sel);
    endtask

    // Waits for the result, checks the done->m_valid latency, optionally
    // stalls m_ready for hold cycles, then consumes the result.
    task automatic recv(input int sel, input int hold, output logic [63:0] dout);
        int n;
        logic p1, p2;
        logic [63:0] saved;
        p1 = cdone[sel]; p2 = 1'b1; n = 0;
        while (!m_valid[sel] && n < LIMIT) begin
            @(negedge clk); n++;
            if (!m_valid[sel]) begin p2 = p1; p1 = cdone[sel]; end
        end
        chk("result_wait", {63'b0, n < LIMIT}, 64'd1);
        chk("mvalid_latency", {62'b0, p2, p1}, 64'd1);
        saved = m_data[sel];
        if (hold > 0) s_valid[sel] = 1'b1;
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            chk("hold_state", {59'b0, m_valid[sel], s_ready[sel], cstart[sel], busy[sel], 1'b1}, 64'b10011);
            chk("hold_data", m_data[sel], saved);
        end
        s_valid[sel] = 1'b0;
        @(negedge clk);
        dout = m_data[sel];
        m_ready[sel] = 1'b1;
        @(posedge clk); #1 m_ready[sel] = 1'b0;
    endtask

    task automatic xfer(input int sel, input logic [63:0] din, input logic mode,
                        input int hold, output logic [63:0] dout);
        send(sel, din, mode);
        recv(sel, hold, dout);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [63:0] d, c1, c2, cprev, expv;
        logic [63:0] pt [4];
        logic [63:0] ct [4];
        n_assert = 0; n_fail = 0;
        rst = 1'b1; hang = 1'b0;
        cfg_mode = ENC; cfg_key = '0; cfg_iv = '0; cfg_load = 1'b0; s_data = '0;
        for (int i = 0; i < 2; i++) begin s_valid[i] = 1'b0; m_ready[i] = 1'b0; end

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_flags", {58'b0, s_ready[0], m_valid[0], busy[0], cstart[0], err[0], 1'b0}, 64'd0);
        chk("rst_mdata", m_data[0], 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {63'b0, s_ready[0]}, 64'd1);

        // ECB instance: known vector, no chaining, decrypt back
        xfer(1, 64'd0, ENC, 0, d);  chk("ecb_enc0", d, TEA0);
        xfer(1, 64'd0, ENC, 0, d);  chk("ecb_enc0_again", d, TEA0);
        xfer(1, TEA0, DEC, 0, d);   chk("ecb_dec", d, 64'd0);

        // CBC, key 0, IV 0, two zero blocks, then decrypt them
        load_iv(64'd0);
        xfer(0, 64'd0, ENC, 0, c1); chk("cbc_enc1", c1, TEA0);
        xfer(0, 64'd0, ENC, 0, c2); chk("cbc_enc2", c2, tea(ENC, TEA0, 128'd0));
        load_iv(64'd0);
        xfer(0, c1, DEC, 0, d);     chk("cbc_dec1", d, 64'd0);
        xfer(0, c2, DEC, 0, d);     chk("cbc_dec2", d, 64'd0);

        // CBC round trip with a non-trivial key and IV
        pt[0] = 64'h3C5A_9F01_77E2_0B4D; pt[1] = 64'hFFFF_FFFF_0000_0000;
        pt[2] = 64'h0000_0001_8000_0000; pt[3] = 64'hDEAD_BEEF_CAFE_F00D;
        cfg_key = KEY3;
        load_iv(IV3);
        cprev = IV3;
        for (int i = 0; i < 4; i++) begin
            expv = tea(ENC, pt[i] ^ cprev, KEY3);
            xfer(0, pt[i], ENC, 0, ct[i]);
            chk("rt_enc", ct[i], expv);
            cprev = expv;
        end
        load_iv(IV3);
        for (int i = 0; i < 4; i++) begin
            xfer(0, ct[i], DEC, 0, d);
            chk("rt_dec", d, pt[i]);
        end

        // Output back-pressure: m_ready low for 20 cycles with s_valid pending
        cfg_key = 128'd0;
        load_iv(64'd0);
        xfer(0, 64'd0, ENC, 20, c1);
        chk("stall_result", c1, TEA0);

        // Watchdog: core never completes
        hang = 1'b1;
        @(negedge clk);
        cfg_mode = ENC; s_data = 64'd0; s_valid[0] = 1'b1;
        @(posedge clk); #1 s_valid[0] = 1'b0;
        @(negedge clk);
        chk("to_start", {63'b0, cstart[0]}, 64'd1);
        repeat (16) @(negedge clk);
        chk("to_before", {62'b0, err[0], busy[0]}, 64'b01);
        @(negedge clk);
        chk("to_flag", {60'b0, err[0], busy[0], s_ready[0], m_valid[0]}, 64'b1010);
        hang = 1'b0;
        xfer(0, 64'd0, ENC, 0, d);
        chk("to_chain_kept", d, tea(ENC, TEA0, 128'd0));
        chk("to_sticky", {63'b0, err[0]}, 64'd1);
        load_iv(64'd0);
        @(negedge clk);
        chk("to_cleared", {63'b0, err[0]}, 64'd0);

        // Reset while waiting on the core
        cfg_key = KEY3;
        send(0, 64'h1111_2222_3333_4444, ENC);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_flags", {58'b0, s_ready[0], m_valid[0], busy[0], cstart[0], err[0], 1'b0}, 64'd0);
        chk("midrst_core", {cv0[0], ck0[0]}, 64'd0);
        chk("midrst_mdata", m_data[0], 64'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        cfg_key = 128'd0;
        xfer(0, 64'd0, ENC, 0, d);
        chk("post_rst_chain0", d, TEA0);

        // cfg_load and s_valid together: load first, block the cycle after
        @(negedge clk);
        cfg_iv = IV3; cfg_load = 1'b1; cfg_mode = ENC; s_data = 64'd0; s_valid[0] = 1'b1;
        #1;
        chk("load_prio_ready", {63'b0, s_ready[0]}, 64'd0);
        @(posedge clk); #1 cfg_load = 1'b0;
        @(negedge clk);
        chk("load_prio_wait", {62'b0, busy[0], s_ready[0]}, 64'b01);
        @(posedge clk); #1 s_valid[0] = 1'b0;
        issue_chk(0);
        recv(0, 0, d);
        chk("load_prio_result", d, tea(ENC, IV3, 128'd0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
